// File: rtl/mips_wb_scoreboard.sv
// Register-writeback scoreboard: counts outstanding writes per architectural
// register and holds issue while a source or destination resource is busy.
module mips_wb_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 8,
  parameter int INF_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs,
  input  logic             issue_rs_used,
  input  logic [4:0]       issue_rt,
  input  logic             issue_rt_used,
  input  logic             issue_wr_en,
  input  logic [4:0]       issue_wr_addr,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  output logic [31:0]      pending,
  output logic [INF_W-1:0] inflight,
  output logic             wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

  // Entry 0 is a constant zero so $0 lookups need no special casing.
  logic [CNT_W-1:0] cnt_view [32];
  logic [INF_W-1:0] inflight_reg;
  logic             wb_err_reg;

  logic rs_haz, rt_haz, wr_block, issue_fire, trk, ret, wb_bad;

  always_comb begin
    rs_haz      = issue_rs_used && (issue_rs != 5'd0) && (cnt_view[issue_rs] != '0);
    rt_haz      = issue_rt_used && (issue_rt != 5'd0) && (cnt_view[issue_rt] != '0);
    wr_block    = issue_wr_en && (issue_wr_addr != 5'd0) &&
                  ((cnt_view[issue_wr_addr] == CNT_MAX) || (inflight_reg == INF_MAX));
    issue_ready = rst_n && !rs_haz && !rt_haz && !wr_block;
    issue_fire  = issue_valid && issue_ready;
    trk         = issue_fire && issue_wr_en && (issue_wr_addr != 5'd0);
    ret         = wb_valid && (wb_addr != 5'd0) && (cnt_view[wb_addr] != '0);
    wb_bad      = wb_valid && (wb_addr != 5'd0) && (cnt_view[wb_addr] == '0);
  end

  assign cnt_view[0] = '0;
  assign pending[0]  = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic             trk_hit, ret_hit;

      assign trk_hit = trk && (issue_wr_addr == 5'(gi));
      assign ret_hit = ret && (wb_addr == 5'(gi));

      // A simultaneous issue and retire on the same register cancel out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt_reg <= '0;
        else if (trk_hit && !ret_hit)
          cnt_reg <= cnt_reg + 1'b1;
        else if (ret_hit && !trk_hit)
          cnt_reg <= cnt_reg - 1'b1;
      end

      assign cnt_view[gi] = cnt_reg;
      assign pending[gi]  = (cnt_reg != '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= '0;
      wb_err_reg   <= 1'b0;
    end else begin
      inflight_reg <= inflight_reg + INF_W'(trk) - INF_W'(ret);
      if (wb_bad)
        wb_err_reg <= 1'b1;
    end
  end

  assign inflight = inflight_reg;
  assign wb_err   = wb_err_reg;

endmodule

// File: tb/tb_mips_wb_scoreboard.sv
// Directed bench for mips_wb_scoreboard: hazards, WAW stacking, saturation,
// illegal writebacks and asynchronous reset.
module tb_mips_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_rs_used, issue_rt_used, issue_wr_en;
  logic [4:0]  issue_rs, issue_rt, issue_wr_addr;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] pending;
  logic [3:0]  inflight;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  mips_wb_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(8), .INF_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
    .issue_rt(issue_rt), .issue_rt_used(issue_rt_used),
    .issue_wr_en(issue_wr_en), .issue_wr_addr(issue_wr_addr),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .pending(pending), .inflight(inflight), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else
      $display("ok   %s: %h", tag, got);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rs_used = 0; issue_rt = 0; issue_rt_used = 0;
    issue_wr_en = 0; issue_wr_addr = 0; wb_valid = 0; wb_addr = 0;
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue_wr(input logic [4:0] a);
    idle(); issue_valid = 1; issue_wr_en = 1; issue_wr_addr = a;
  endtask

  task automatic wb(input logic [4:0] a);
    idle(); wb_valid = 1; wb_addr = a;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2 chk("ready_in_reset", {31'd0, issue_ready}, 32'd0);
    cyc(); cyc();
    rst_n = 1;
    issue_valid = 1; issue_rs = 5; issue_rs_used = 1; issue_wr_en = 1; issue_wr_addr = 3;
    issue_valid = 0;
    #1;
    chk("rst_pending", pending, 32'd0);
    chk("rst_inflight", {28'd0, inflight}, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    cyc();

    // RAW on $5
    issue_wr(5);
    #1 chk("raw_issue_ready", {31'd0, issue_ready}, 32'd1);
    cyc();
    chk("raw_pending5", pending, 32'h0000_0020);
    chk("raw_inflight1", {28'd0, inflight}, 32'd1);
    idle(); issue_valid = 1; issue_rs = 5; issue_rs_used = 1;
    #1 chk("raw_stall", {31'd0, issue_ready}, 32'd0);
    cyc();
    wb_valid = 1; wb_addr = 5;
    #1 chk("raw_same_cycle_wb_stall", {31'd0, issue_ready}, 32'd0);
    cyc();
    wb_valid = 0;
    #1;
    chk("raw_released", {31'd0, issue_ready}, 32'd1);
    chk("raw_pending_clear", pending, 32'd0);
    chk("raw_inflight0", {28'd0, inflight}, 32'd0);
    cyc();

    // Link write to $31, $0 sources, untracked $0 destination
    issue_wr(31);
    cyc();
    chk("link_pending31", pending, 32'h8000_0000);
    idle(); issue_valid = 1; issue_rt = 31; issue_rt_used = 1;
    #1 chk("link_stall", {31'd0, issue_ready}, 32'd0);
    idle(); issue_valid = 1; issue_rs_used = 1; issue_rt_used = 1;
    #1 chk("zero_src_no_stall", {31'd0, issue_ready}, 32'd1);
    cyc();
    wb(31);
    cyc();
    chk("link_cleared", pending, 32'd0);
    issue_wr(0);
    cyc();
    chk("wr0_untracked", {28'd0, inflight}, 32'd0);

    // WAW stacking on $7 up to saturation
    issue_wr(7); cyc(); cyc(); cyc();
    chk("waw_inflight3", {28'd0, inflight}, 32'd3);
    chk("waw_pending7", pending, 32'h0000_0080);
    #1 chk("waw_sat_stall", {31'd0, issue_ready}, 32'd0);
    wb_valid = 1; wb_addr = 7;
    #1 chk("waw_sat_same_cycle_ret", {31'd0, issue_ready}, 32'd0);
    cyc();
    wb_valid = 0;
    chk("waw_after_ret", {28'd0, inflight}, 32'd2);
    #1 chk("waw_fourth_ready", {31'd0, issue_ready}, 32'd1);
    cyc();
    chk("waw_inflight_back3", {28'd0, inflight}, 32'd3);
    wb(7); cyc(); cyc(); cyc();
    chk("waw_drained", {28'd0, inflight}, 32'd0);
    chk("waw_no_err", {31'd0, wb_err}, 32'd0);

    // Same-cycle issue and retire on $9
    issue_wr(9);
    cyc();
    wb_valid = 1; wb_addr = 9;
    #1 chk("same9_ready", {31'd0, issue_ready}, 32'd1);
    cyc();
    chk("same9_pending", pending, 32'h0000_0200);
    chk("same9_inflight", {28'd0, inflight}, 32'd1);
    wb(9);
    cyc();
    chk("same9_clear", {28'd0, inflight}, 32'd0);

    // Global in-flight limit
    for (int r = 1; r <= 8; r++) begin
      issue_wr(5'(r));
      cyc();
    end
    chk("full_inflight8", {28'd0, inflight}, 32'd8);
    chk("full_pending", pending, 32'h0000_01fe);
    issue_wr(10);
    #1 chk("full_stall", {31'd0, issue_ready}, 32'd0);
    issue_wr(0);
    #1 chk("full_wr0_no_stall", {31'd0, issue_ready}, 32'd1);
    idle(); issue_valid = 1; issue_rs = 20; issue_rs_used = 1;
    #1 chk("full_read_ok", {31'd0, issue_ready}, 32'd1);
    idle();
    cyc();

    // Illegal writeback and sticky error
    wb(20);
    cyc();
    chk("err_set", {31'd0, wb_err}, 32'd1);
    chk("err_inflight_same", {28'd0, inflight}, 32'd8);
    wb(0);
    cyc();
    wb(1);
    cyc();
    chk("err_sticky", {31'd0, wb_err}, 32'd1);
    chk("ret_inflight7", {28'd0, inflight}, 32'd7);
    issue_wr(10);
    #1 chk("room_ready", {31'd0, issue_ready}, 32'd1);
    wb(2); cyc(); wb(3); cyc(); wb(4); cyc(); wb(5); cyc();
    idle();
    chk("three_left", {28'd0, inflight}, 32'd3);

    // Asynchronous reset mid-cycle
    #2 rst_n = 0;
    #1;
    chk("async_pending", pending, 32'd0);
    chk("async_inflight", {28'd0, inflight}, 32'd0);
    chk("async_wb_err", {31'd0, wb_err}, 32'd0);
    chk("async_ready", {31'd0, issue_ready}, 32'd0);
    cyc();
    rst_n = 1;
    #1 chk("post_reset_ready", {31'd0, issue_ready}, 32'd1);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
